// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: function codes,
// FSM state encoding and the divide-by-zero LO value.
package mdu_pkg;

    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of the shift-add multiplier / restoring shift-subtract divider.
// Multiply: acc = {partial product, remaining multiplier}. Divide: acc = {rem, quot}.
module md_iter_core (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic        fits;
    logic [31:0] rem_sub;

    always_comb begin
        sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
        // Shifted remainder is 33 bits wide; the difference always fits in 32 when it commits.
        fits     = acc[63:31] >= {1'b0, operand};
        rem_sub  = acc[62:31] - operand;
        acc_next = {sum, acc[31:1]};
        if (is_div) begin
            if (fits) acc_next = {rem_sub, acc[30:0], 1'b1};
            else      acc_next = {acc[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MIPS multiply/divide unit owning HI/LO; stalls the pipeline via busy
// while a 32-step MULT/MULTU/DIV/DIVU runs.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Function_opcode,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic        mt_done;
    logic        is_div, is_signed, neg_q, neg_r;
    logic [31:0] a_reg, b_reg;
    logic [63:0] acc, acc_step;
    logic        accept, is_md, is_mt;
    logic [31:0] fix_hi, fix_lo;

    md_iter_core u_core (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (b_reg),
        .acc_next (acc_step)
    );

    always_comb begin
        accept     = start && (state == ST_IDLE || state == ST_DONE);
        is_md      = Function_opcode == FUNC_MULT || Function_opcode == FUNC_MULTU ||
                     Function_opcode == FUNC_DIV  || Function_opcode == FUNC_DIVU;
        is_mt      = Function_opcode == FUNC_MTHI || Function_opcode == FUNC_MTLO;
        state_next = state;
        busy       = 1'b0;
        done       = mt_done;
        case (state)
            ST_IDLE, ST_DONE: begin
                done       = mt_done || (state == ST_DONE);
                state_next = (accept && is_md) ? ST_PREP : ST_IDLE;
            end
            ST_PREP: begin
                busy       = 1'b1;
                state_next = (is_div && b_reg == 32'd0) ? ST_FIX : ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == 6'(ITER - 1)) state_next = ST_FIX;
            end
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fix_hi = acc[63:32];
        fix_lo = acc[31:0];
        if (!is_div) begin
            {fix_hi, fix_lo} = neg_q ? -acc : acc;
        end else if (b_reg == 32'd0) begin
            fix_hi = a_reg;
            fix_lo = DIV0_LO;
        end else begin
            fix_lo = neg_q ? -acc[31:0]  : acc[31:0];
            fix_hi = neg_r ? -acc[63:32] : acc[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 6'd0;
            mt_done <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state   <= state_next;
            mt_done <= accept && is_mt;
            if (state == ST_PREP)      cnt <= 6'd0;
            else if (state == ST_CALC) cnt <= cnt + 6'd1;
            if (accept && Function_opcode == FUNC_MTHI) HI <= Read_data_1;
            if (accept && Function_opcode == FUNC_MTLO) LO <= Read_data_1;
            if (state == ST_FIX) begin
                HI <= fix_hi;
                LO <= fix_lo;
            end
        end
    end

    // Datapath: a_reg keeps the raw dividend for the divide-by-zero result;
    // b_reg becomes the magnitude operand fed to the iteration core.
    always_ff @(posedge clock) begin
        if (accept && is_md) begin
            a_reg     <= Read_data_1;
            b_reg     <= Read_data_2;
            is_div    <= Function_opcode[1];
            is_signed <= ~Function_opcode[0];
        end
        case (state)
            ST_PREP: begin
                neg_q <= is_signed && (a_reg[31] ^ b_reg[31]);
                neg_r <= is_signed && a_reg[31];
                if (is_div) begin
                    acc   <= {32'd0, abs32(a_reg, is_signed)};
                    b_reg <= abs32(b_reg, is_signed);
                end else begin
                    acc   <= {32'd0, abs32(b_reg, is_signed)};
                    b_reg <= abs32(a_reg, is_signed);
                end
            end
            ST_CALC: acc <= acc_step;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random
// back-to-back operations against a plain-arithmetic HI/LO model.
module tb_mdu_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  fop   = 6'd0;
    logic [31:0] rd1   = 32'd0;
    logic [31:0] rd2   = 32'd0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_sequencer #(.ITER(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .Function_opcode (fop),
        .Read_data_1     (rd1),
        .Read_data_2     (rd2),
        .busy            (busy),
        .done            (done),
        .HI              (HI),
        .LO              (LO)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint sa, sb, p;
        logic [63:0] up;
        lat = 35;
        hi  = 32'd0;
        lo  = 32'd0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            6'h18: begin p = sa * sb; {hi, lo} = p; end
            6'h19: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 3;
                end else if (op == 6'h1A) begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb);
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Starts an op at the next edge (k) and follows it to done; intr_at>0 pulses a MULT start mid-flight.
    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int intr_at);
        logic [31:0] mhi, mlo;
        int lat, nbusy, got_at;
        bit stable;
        model(op, a, b, mhi, mlo, lat);
        start = 1'b1; fop = op; rd1 = a; rd2 = b;
        @(posedge clock); #1;
        start = 1'b0; rd1 = $urandom; rd2 = $urandom;
        nbusy = 0; got_at = 0; stable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == intr_at) begin start = 1'b1; fop = 6'h18; end
            else start = 1'b0;
            if (done) begin got_at = c; break; end
            if (busy) nbusy++;
            if (HI !== exp_hi || LO !== exp_lo) stable = 1'b0;
            @(posedge clock); #1;
        end
        start = 1'b0;
        n_cmp++;
        if (got_at !== lat) begin
            n_err++; $display("FAIL %s done_cycle got=%0d want=%0d (0=timeout)", name, got_at, lat);
        end
        n_cmp++;
        if (HI !== mhi) begin n_err++; $display("FAIL %s HI got=%h want=%h", name, HI, mhi); end
        n_cmp++;
        if (LO !== mlo) begin n_err++; $display("FAIL %s LO got=%h want=%h", name, LO, mlo); end
        n_cmp++;
        if (nbusy !== lat - 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s busy_cycles got=%0d/%b want=%0d/0", name, nbusy, busy, lat - 1);
        end
        n_cmp++;
        if (!stable) begin n_err++; $display("FAIL %s hilo_stable got=changed want=held", name); end
        exp_hi = mhi; exp_lo = mlo;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            n_err++; $display("FAIL reset_hilo got=%h/%h want=0/0", HI, LO);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl got=%b%b want=00", busy, done);
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_directed;
        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_neg",  6'h18, -32'sd3, 32'd5, 0);
        run_op("div_neg",   6'h1A, -32'sd7, 32'd2, 0);
        run_op("divu_small", 6'h1B, 32'd7, 32'd2, 0);
        run_op("divu_zero", 6'h1B, 32'h0000_1234, 32'd0, 0);
        run_op("div_ovf",   6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_zero_s", 6'h1A, 32'h8765_4321, 32'd0, 0);
        run_op("mult_min",  6'h18, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_rneg",  6'h1A, 32'd7, -32'sd2, 0);
    endtask

    task automatic test_mt_and_ignore;
        logic [31:0] v;
        start = 1'b1; fop = 6'h11; rd1 = 32'hA5A5_A5A5; rd2 = $urandom;
        @(posedge clock); #1;
        start = 1'b0;
        exp_hi = 32'hA5A5_A5A5;
        n_cmp++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            n_err++; $display("FAIL mthi_hilo got=%h/%h want=%h/%h", HI, LO, exp_hi, exp_lo);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL mthi_ctl done/busy got=%b/%b want=1/0", done, busy);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mthi_after done/busy got=%b/%b want=0/0", done, busy);
        end
        v = $urandom;
        start = 1'b1; fop = 6'h13; rd1 = v;
        @(posedge clock); #1;
        start = 1'b0;
        exp_lo = v;
        n_cmp++;
        if (LO !== exp_lo || HI !== exp_hi || done !== 1'b1) begin
            n_err++; $display("FAIL mtlo got=%h/%h/%b want=%h/%h/1", HI, LO, done, exp_hi, exp_lo);
        end
        run_op("div_ignore_start", 6'h1A, 32'h7FFF_0001, 32'd13, 10);
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if (i % 5 == 3) b = b >> $urandom_range(0, 31);
            run_op("random", ops[$urandom_range(0, 3)], a, b, 0);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_width done/busy got=%b/%b want=0/0", done, busy);
        end
    endtask

    task automatic test_reset_abort;
        bit saw_done;
        start = 1'b1; fop = 6'h18; rd1 = $urandom; rd2 = $urandom;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort_ctl busy/done got=%b/%b want=0/0", busy, done);
        end
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            n_err++; $display("FAIL abort_hilo got=%h/%h want=0/0", HI, LO);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) saw_done = 1'b1;
            @(posedge clock); #1;
        end
        n_cmp++;
        if (saw_done || HI !== 32'd0 || LO !== 32'd0) begin
            n_err++; $display("FAIL abort_quiet got=%b/%h/%h want=0/0/0", saw_done, HI, LO);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_mt_and_ignore;
        test_back_to_back;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
